c_split_1ton: RTL and testbench



---
 rtl/c_split_1ton.sv | 128 ++++++++++++
 tb/tb_c_split_1ton.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/c_split_1ton.sv
// c_split_1ton
//   Splits one aggregate total (e.g. credits or flits) greedily across
//   num_ports per-port slices of width bits. Each slice can hold up to
//   MAXV = 2**width-1. Leading slices are filled to MAXV, then at most one
//   partial slice follows, then zeros. One slice is written per cycle, so the
//   latency is fixed regardless of the total.
//
// Ports
//   clk        clock, all state updates on posedge
//   reset      synchronous active-high reset
//   in_valid   data_in is valid
//   in_ready   block can accept a total (IDLE)
//   data_in    total to split, clog2(num_ports)+width bits, unsigned
//   out_valid  data_out/out_error valid (DONE)
//   out_ready  consumer accepts the result
//   data_out   port p value at [p*width +: width]
//   out_error  total exceeded num_ports*MAXV; data_out is saturated
module c_split_1ton #(
  parameter int num_ports = 4,
  parameter int width     = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [$clog2(num_ports)+width-1:0]     data_in,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [num_ports*width-1:0]             data_out,
  output logic                                   out_error
);

  localparam int TW = $clog2(num_ports) + width;
  // Port index needs at least one bit even when there is a single port.
  localparam int IW = (num_ports > 1) ? $clog2(num_ports) : 1;
  localparam logic [TW-1:0] MAXV = TW'({width{1'b1}});
  localparam logic [IW-1:0] LAST = IW'(num_ports - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [TW-1:0]              r_rem;
  logic [IW-1:0]              r_idx;
  logic                       r_error;
  logic [num_ports*width-1:0] r_data;

  logic                       w_accept;
  logic                       w_fill;
  logic                       w_last;
  logic [TW-1:0]              w_take_full;
  logic [width-1:0]           w_take;
  logic [TW-1:0]              w_rem_after;

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_fill   = (r_state == S_FILL);
  assign w_last   = w_fill && (r_idx == LAST);

  // min(rem, MAXV) at full remainder width; the result always fits in a
  // slice, and subtracting it from rem can never underflow.
  assign w_take_full = (r_rem > MAXV) ? MAXV : r_rem;
  assign w_take      = w_take_full[width-1:0];
  assign w_rem_after = r_rem - w_take_full;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid)  w_state_next = S_FILL;
      S_FILL: if (w_last)    w_state_next = S_DONE;
      S_DONE: if (out_ready) w_state_next = S_IDLE;
      default:               w_state_next = S_IDLE;
    endcase
  end

  // Remainder, port index and overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem   <= '0;
      r_idx   <= '0;
      r_error <= 1'b0;
    end else if (w_accept) begin
      r_rem   <= data_in;
      r_idx   <= '0;
      r_error <= 1'b0;
    end else if (w_fill) begin
      r_rem <= w_rem_after;
      r_idx <= r_idx + IW'(1);
      // Anything left after the last slice could not be represented.
      if (w_last) r_error <= (w_rem_after != '0);
    end
  end

  // One register per slice; slice gi is written only in its FILL cycle and
  // otherwise holds, so the result stays stable through DONE and IDLE.
  generate
    for (genvar gi = 0; gi < num_ports; gi++) begin : g_slice
      always_ff @(posedge clk) begin
        if (reset) begin
          r_data[gi*width +: width] <= '0;
        end else if (w_accept) begin
          r_data[gi*width +: width] <= '0;
        end else if (w_fill && (r_idx == IW'(gi))) begin
          r_data[gi*width +: width] <= w_take;
        end
      end
    end
  endgenerate

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign data_out  = r_data;
  assign out_error = r_error;

endmodule

// File: tb/tb_c_split_1ton.sv
module tb_c_split_1ton;

  localparam int NP = 4;
  localparam int W  = 8;
  localparam int TW = 10;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [TW-1:0]   data_in = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [NP*W-1:0] data_out;
  logic            out_error;

  c_split_1ton #(.num_ports(NP), .width(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .out_error (out_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NP*W-1:0] dout;
    logic            err;
    logic [TW-1:0]   din;
    int              acc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   rnd_ready = 0;
  bit   done_sim = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Closed-form greedy split: d/255 full slices, then d%255, then zeros.
  function automatic logic [NP*W-1:0] split_model(input int d);
    logic [NP*W-1:0] r;
    int full, part;
    r = '0;
    if (d > NP*255) begin
      for (int p = 0; p < NP; p++) r[p*W +: W] = 8'd255;
    end else begin
      full = d / 255;
      part = d % 255;
      for (int p = 0; p < NP; p++) begin
        if (p < full)       r[p*W +: W] = 8'd255;
        else if (p == full) r[p*W +: W] = part[7:0];
      end
    end
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: pops one expectation when out_valid rises, then checks the
  // result stays stable for as long as out_valid is held.
  initial begin
    exp_t cur;
    bit   prev_ov = 0;
    cur = '{dout: '0, err: 1'b0, din: '0, acc: 0};
    forever begin
      @(negedge clk);
      if (!reset && out_valid === 1'b1) begin
        if (!prev_ov) begin
          if (q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL unexpected_out: got data_out=%h with empty queue", data_out);
          end else begin
            int sum;
            bit mono;
            cur = q.pop_front();
            chk("latency", 64'(cyc - cur.acc), 64'(NP));
            chk("data_out", 64'(data_out), 64'(cur.dout));
            chk("out_error", 64'(out_error), 64'(cur.err));
            sum = 0; mono = 1;
            for (int p = 0; p < NP; p++) begin
              sum += int'(data_out[p*W +: W]);
              if (p > 0 && data_out[p*W +: W] > data_out[(p-1)*W +: W]) mono = 0;
            end
            chk("sum_eq_iff_ok", 64'(sum == int'(cur.din)), 64'(!out_error));
            chk("nonincreasing", 64'(mono), 64'd1);
            $display("out: din=%0d data_out={%0d,%0d,%0d,%0d} err=%0d", cur.din,
                     data_out[31:24], data_out[23:16], data_out[15:8], data_out[7:0], out_error);
          end
        end else begin
          chk("hold_data", 64'(data_out), 64'(cur.dout));
          chk("hold_err", 64'(out_error), 64'(cur.err));
        end
      end
      prev_ov = (!reset && out_valid === 1'b1);
    end
  end

  // Issue one total; returns at the negedge just after the accept edge.
  task automatic send(input int d, input bit push, input logic [NP*W-1:0] ed, input bit ee);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_chk++; n_err++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    in_valid = 1'b1;
    data_in  = TW'(d);
    if (push) q.push_back('{dout: ed, err: ee, din: TW'(d), acc: cyc + 1});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int t = 0;
    while (out_valid !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("out_valid_timeout", 64'(out_valid), 64'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_data_out", 64'(data_out), 64'd0);
    chk("rst_out_error", 64'(out_error), 64'd0);

    // Directed totals, consumer always ready.
    send(0, 1, 32'h00000000, 0);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    send(600, 1, {8'd0, 8'd90, 8'd255, 8'd255}, 0);
    send(255, 1, {8'd0, 8'd0, 8'd0, 8'd255}, 0);
    send(256, 1, {8'd0, 8'd0, 8'd1, 8'd255}, 0);
    send(1020, 1, {8'd255, 8'd255, 8'd255, 8'd255}, 0);
    send(1021, 1, {8'd255, 8'd255, 8'd255, 8'd255}, 1);
    send(1023, 1, {8'd255, 8'd255, 8'd255, 8'd255}, 1);
    @(negedge clk);
    wait_valid();
    @(negedge clk);

    // Backpressure with spurious in_valid during FILL and DONE.
    out_ready = 1'b0;
    send(1021, 1, {8'd255, 8'd255, 8'd255, 8'd255}, 1);
    in_valid = 1'b1;
    data_in  = TW'(7);
    repeat (3) begin
      @(negedge clk);
      chk("busy_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      in_valid = (i == 2);
    end
    in_valid  = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 64'(in_ready), 64'd1);
    chk("release_out_valid", 64'(out_valid), 64'd0);
    send(256, 1, {8'd0, 8'd0, 8'd1, 8'd255}, 0);
    @(negedge clk);
    wait_valid();

    // Reset in the second FILL cycle aborts the operation.
    send(600, 0, '0, 0);
    @(negedge clk);
    chk("mid_fill_slice0", 64'(data_out[7:0]), 64'd255);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_data_out", 64'(data_out), 64'd0);
    chk("abort_out_error", 64'(out_error), 64'd0);
    reset = 1'b0;
    send(300, 1, {8'd0, 8'd0, 8'd45, 8'd255}, 0);
    @(negedge clk);
    wait_valid();

    // Random totals with random consumer readiness.
    rnd_ready = 1;
    for (int i = 0; i < 1000; i++) begin
      int d;
      d = int'($urandom_range(0, 1023));
      send(d, 1, split_model(d), d > NP * 255);
    end

    begin
      int t = 0;
      while ((q.size() != 0 || !in_ready) && t < 200) begin
        @(negedge clk);
        t++;
      end
      chk("drain_queue_empty", 64'(q.size()), 64'd0);
    end
    rnd_ready = 0;
    done_sim  = 1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    if (!done_sim) begin
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
    end
  end

endmodule
